cache_port_arbiter: RTL and testbench
=====================================

Name: cache_port_arbiter

Overview:
- Shares the single user port of the write-back cache controller (rd_en/wr_en/addr/data/mask/busy) between two requesters: port 0 (instruction fetch) and port 1 (load/store).
- Latches each granted request, then runs exactly one downstream transaction: a one-cycle enable pulse followed by the busy handshake. Address, data and mask are held stable for the whole transaction, because the controller re-reads them during miss handling.
- Returns read data and a done pulse to the owner.
- Sits between the Hazard3 bus adapters and the cache controller.

Parameters:
- TIMEOUT, 4096: maximum cycles m_busy may stay high before the transaction is aborted.
- FIXED_PRIO, 0: 0 = round-robin; 1 = port 1 always wins a simultaneous request.

Ports:
- clk  in  1  system clock
- rst_x  in  1  asynchronous active-low reset
- s0_req, s1_req  in  1  request valid; held until granted
- s0_gnt, s1_gnt  out  1  combinational accept; the request is consumed when req && gnt
- s0_we, s1_we  in  1  1 = write, 0 = read
- s0_addr, s1_addr  in  32  byte address
- s0_wdata, s1_wdata  in  32  write data
- s0_mask, s1_mask  in  4  byte enables (writes only)
- s0_rdata, s1_rdata  out  32  read data; valid with done, held until that port's next done
- s0_done, s1_done  out  1  one-cycle completion pulse
- m_rd_en, m_wr_en  out  1  controller enables (one-cycle pulses)
- m_addr, m_wdata  out  32  held request fields
- m_mask  out  4  held mask; forced to 4'b1111 for reads
- m_rdata  in  32  controller o_data
- m_busy  in  1  controller o_busy
- m_hit  in  1  controller cache-hit indication (c_oe)
- o_err  out  1  sticky protocol/timeout error

Behaviour:
- Reset: every output and register is 0, state = IDLE, the round-robin pointer favours port 0, o_err = 0. A reset mid-transaction aborts it silently; no done pulse is produced.
- States: IDLE, ISSUE, WAIT_RISE, WAIT_FALL, DONE.
- IDLE:
  - gnt is asserted combinationally to the arbitration winner only. With a single requester, that requester wins.
  - Round-robin: on a simultaneous request the port not granted last wins. The pointer updates on each grant.
  - On grant, latch owner/we/addr/wdata/mask.
  - Read, or write with mask != 0: go to ISSUE with m_rd_en or m_wr_en = 1 (registered).
  - Write with mask == 0: no downstream access; go to DONE.
- ISSUE (one cycle): enable high.
  - Read with m_hit = 1: capture m_rdata, go to DONE.
  - Otherwise: go to WAIT_RISE.
  - Enables clear on exit.
- WAIT_RISE (one cycle): enables low.
  - m_busy = 1: go to WAIT_FALL, clear the timeout counter.
  - m_busy = 0: protocol error; set o_err, rdata = 0, go to DONE.
- WAIT_FALL: counter increments each cycle.
  - m_busy = 0: capture m_rdata (reads), go to DONE.
  - Counter reaches TIMEOUT-1 with busy still high: set o_err, rdata = 0, go to DONE.
  - A write-hit (busy high for one cycle) completes on the first WAIT_FALL cycle.
- DONE (one cycle): the owner's done = 1, and its rdata is updated on the entry edge. Go to IDLE; no grant is given in DONE.
- Latency from grant cycle to done cycle:
  - read hit: 2 cycles
  - zero-mask write: 1 cycle
  - miss/write: 3 + busy-length cycles
- Latched fields are never modified outside IDLE. Requesters may change their inputs freely after their gnt.
- A request that arrives during a transaction waits; gnt stays low outside IDLE.
- Write completion leaves the port's rdata unchanged.

Decomposition:
- Shared package cache_arb_pkg: state encodings, ERR_RDATA = 32'h0, MASK_ALL = 4'b1111, the $clog2(TIMEOUT) counter width function.
- Sub-module rr_arb2: two requests, last-grant pointer, FIXED_PRIO; combinational grant plus pointer register.

Test Plan:
- Port 0 reads 0x100 with the model returning m_hit = 1 and m_rdata = 0x11223344 -> s0_gnt in cycle 0, m_rd_en only in cycle 1, s0_done in cycle 2 with s0_rdata = 0x11223344; m_wr_en never asserted.
- Port 1 writes 0xA5A5A5A5 with mask 4'b0011 to 0x200 on a miss; the model holds busy for 6 cycles -> m_addr/m_wdata/m_mask stay at 0x200/0xA5A5A5A5/0011 throughout, single m_wr_en pulse, s1_done on the cycle after busy falls.
- Both ports request every cycle for 6 transactions, round-robin -> grants alternate 0,1,0,1,0,1 (first to port 0 after reset); with FIXED_PRIO = 1 every grant goes to port 1.
- Port 0 writes with mask 0 -> no m_wr_en, s0_done one cycle after grant, o_err stays 0.
- The model never drops busy, TIMEOUT = 16 -> s1_done 16 cycles into WAIT_FALL with s1_rdata = 0 and o_err = 1 sticky; a following read completes normally with o_err still 1.
- rst_x pulsed low during WAIT_FALL -> all outputs 0 immediately, no done, and the next request is granted normally from IDLE.

Source files
------------

// File: rtl/cache_arb_pkg.sv
// Shared types and constants for the two-port cache user-port arbiter.
package cache_arb_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned MASK_W = 4;

  localparam logic [DATA_W-1:0] ERR_RDATA = 32'h0;
  localparam logic [MASK_W-1:0] MASK_ALL  = 4'b1111;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_RISE,
    ST_WAIT_FALL,
    ST_DONE
  } arb_state_e;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [MASK_W-1:0] mask;
  } arb_req_t;

  // Busy-timeout counter width; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned timeout);
    return (timeout > 2) ? $clog2(timeout) : 1;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-requester arbiter: combinational grant, registered favoured-port pointer.
module rr_arb2 #(
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic       clk,
  input  logic       rst_x,
  input  logic       en_i,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_c_o
);

  logic prio_q, prio_d;

  always_comb begin
    gnt_c_o = 2'b00;
    prio_d  = prio_q;
    if (en_i) begin
      unique case (req_i)
        2'b01:   gnt_c_o = 2'b01;
        2'b10:   gnt_c_o = 2'b10;
        2'b11:   gnt_c_o = (FIXED_PRIO || prio_q) ? 2'b10 : 2'b01;
        default: gnt_c_o = 2'b00;
      endcase
    end
    // After a grant, favour the port that was not served.
    if (|gnt_c_o) prio_d = ~gnt_c_o[1];
  end

  always_ff @(posedge clk or negedge rst_x) begin
    if (!rst_x) prio_q <= 1'b0;
    else        prio_q <= prio_d;
  end

endmodule

// File: rtl/cache_port_arbiter.sv
// Shares the cache controller user port between instruction fetch (port 0) and load/store (port 1).
module cache_port_arbiter
  import cache_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT    = 4096,
  parameter bit          FIXED_PRIO = 1'b0
) (
  input  logic              clk,
  input  logic              rst_x,
  input  logic              s0_req,
  input  logic              s1_req,
  output logic              s0_gnt,
  output logic              s1_gnt,
  input  logic              s0_we,
  input  logic              s1_we,
  input  logic [ADDR_W-1:0] s0_addr,
  input  logic [ADDR_W-1:0] s1_addr,
  input  logic [DATA_W-1:0] s0_wdata,
  input  logic [DATA_W-1:0] s1_wdata,
  input  logic [MASK_W-1:0] s0_mask,
  input  logic [MASK_W-1:0] s1_mask,
  output logic [DATA_W-1:0] s0_rdata,
  output logic [DATA_W-1:0] s1_rdata,
  output logic              s0_done,
  output logic              s1_done,
  output logic              m_rd_en,
  output logic              m_wr_en,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  output logic [MASK_W-1:0] m_mask,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic              m_busy,
  input  logic              m_hit,
  output logic              o_err
);

  localparam int unsigned CNT_W = cnt_width(TIMEOUT);

  arb_state_e               state_q, state_d;
  arb_req_t                 req_q, req_d;
  logic                     owner_q, owner_d;
  logic                     rd_en_q, rd_en_d;
  logic                     wr_en_q, wr_en_d;
  logic [1:0]               done_q, done_d;
  logic [1:0][DATA_W-1:0]   rdata_q, rdata_d;
  logic                     err_q, err_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [1:0]               gnt_c;
  arb_req_t                 sel_c;

  rr_arb2 #(.FIXED_PRIO(FIXED_PRIO)) u_arb (
    .clk     (clk),
    .rst_x   (rst_x),
    .en_i    (state_q == ST_IDLE),
    .req_i   ({s1_req, s0_req}),
    .gnt_c_o (gnt_c)
  );

  assign sel_c = gnt_c[1] ? '{we: s1_we, addr: s1_addr, wdata: s1_wdata, mask: s1_mask}
                          : '{we: s0_we, addr: s0_addr, wdata: s0_wdata, mask: s0_mask};

  // Transaction sequencing; done and rdata are set on the edge that enters DONE.
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    owner_d = owner_q;
    rd_en_d = 1'b0;
    wr_en_d = 1'b0;
    done_d  = 2'b00;
    rdata_d = rdata_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (|gnt_c) begin
          owner_d = gnt_c[1];
          req_d   = sel_c;
          if (!sel_c.we) req_d.mask = MASK_ALL;
          if (sel_c.we && (sel_c.mask == '0)) begin
            done_d[gnt_c[1]] = 1'b1;
            state_d          = ST_DONE;
          end else begin
            rd_en_d = ~sel_c.we;
            wr_en_d = sel_c.we;
            state_d = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: begin
        if (!req_q.we && m_hit) begin
          rdata_d[owner_q] = m_rdata;
          done_d[owner_q]  = 1'b1;
          state_d          = ST_DONE;
        end else begin
          state_d = ST_WAIT_RISE;
        end
      end
      ST_WAIT_RISE: begin
        if (m_busy) begin
          cnt_d   = '0;
          state_d = ST_WAIT_FALL;
        end else begin
          err_d            = 1'b1;
          rdata_d[owner_q] = ERR_RDATA;
          done_d[owner_q]  = 1'b1;
          state_d          = ST_DONE;
        end
      end
      ST_WAIT_FALL: begin
        if (!m_busy) begin
          if (!req_q.we) rdata_d[owner_q] = m_rdata;
          done_d[owner_q] = 1'b1;
          state_d         = ST_DONE;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          err_d            = 1'b1;
          rdata_d[owner_q] = ERR_RDATA;
          done_d[owner_q]  = 1'b1;
          state_d          = ST_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_x) begin
    if (!rst_x) begin
      state_q <= ST_IDLE;
      req_q   <= '0;
      owner_q <= 1'b0;
      rd_en_q <= 1'b0;
      wr_en_q <= 1'b0;
      done_q  <= 2'b00;
      rdata_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      owner_q <= owner_d;
      rd_en_q <= rd_en_d;
      wr_en_q <= wr_en_d;
      done_q  <= done_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign s0_gnt   = gnt_c[0];
  assign s1_gnt   = gnt_c[1];
  assign s0_done  = done_q[0];
  assign s1_done  = done_q[1];
  assign s0_rdata = rdata_q[0];
  assign s1_rdata = rdata_q[1];
  assign m_rd_en  = rd_en_q;
  assign m_wr_en  = wr_en_q;
  assign m_addr   = req_q.addr;
  assign m_wdata  = req_q.wdata;
  assign m_mask   = req_q.mask;
  assign o_err    = err_q;

endmodule

// File: tb/tb_cache_port_arbiter.sv
// Bench for cache_port_arbiter: round-robin and fixed-priority instances against a latency-rule model.
module tb_cache_port_arbiter;

  localparam int unsigned TO = 16;

  logic clk = 1'b0;
  logic rst_x;
  logic s0_req, s1_req, s0_we, s1_we;
  logic [31:0] s0_addr, s1_addr, s0_wdata, s1_wdata;
  logic [3:0]  s0_mask, s1_mask;

  logic a_s0_gnt, a_s1_gnt, a_s0_done, a_s1_done, a_m_rd_en, a_m_wr_en, a_o_err, a_m_busy;
  logic [31:0] a_s0_rdata, a_s1_rdata, a_m_addr, a_m_wdata;
  logic [3:0]  a_m_mask;
  logic b_s0_gnt, b_s1_gnt, b_s0_done, b_s1_done, b_m_rd_en, b_m_wr_en, b_o_err, b_m_busy;
  logic [31:0] b_s0_rdata, b_s1_rdata, b_m_addr, b_m_wdata;
  logic [3:0]  b_m_mask;

  logic        cfg_hit;
  logic [31:0] cfg_rdata;
  int unsigned cfg_busy;
  int unsigned busy_left_a, busy_left_b;

  int unsigned checks = 0;
  int unsigned errors = 0;
  logic [31:0] exp_rdata [2];
  logic        exp_err;

  always #5 clk = ~clk;

  cache_port_arbiter #(.TIMEOUT(TO), .FIXED_PRIO(1'b0)) dut_a (
    .clk(clk), .rst_x(rst_x),
    .s0_req(s0_req), .s1_req(s1_req), .s0_gnt(a_s0_gnt), .s1_gnt(a_s1_gnt),
    .s0_we(s0_we), .s1_we(s1_we), .s0_addr(s0_addr), .s1_addr(s1_addr),
    .s0_wdata(s0_wdata), .s1_wdata(s1_wdata), .s0_mask(s0_mask), .s1_mask(s1_mask),
    .s0_rdata(a_s0_rdata), .s1_rdata(a_s1_rdata), .s0_done(a_s0_done), .s1_done(a_s1_done),
    .m_rd_en(a_m_rd_en), .m_wr_en(a_m_wr_en), .m_addr(a_m_addr), .m_wdata(a_m_wdata),
    .m_mask(a_m_mask), .m_rdata(cfg_rdata), .m_busy(a_m_busy), .m_hit(cfg_hit), .o_err(a_o_err)
  );

  cache_port_arbiter #(.TIMEOUT(TO), .FIXED_PRIO(1'b1)) dut_b (
    .clk(clk), .rst_x(rst_x),
    .s0_req(s0_req), .s1_req(s1_req), .s0_gnt(b_s0_gnt), .s1_gnt(b_s1_gnt),
    .s0_we(s0_we), .s1_we(s1_we), .s0_addr(s0_addr), .s1_addr(s1_addr),
    .s0_wdata(s0_wdata), .s1_wdata(s1_wdata), .s0_mask(s0_mask), .s1_mask(s1_mask),
    .s0_rdata(b_s0_rdata), .s1_rdata(b_s1_rdata), .s0_done(b_s0_done), .s1_done(b_s1_done),
    .m_rd_en(b_m_rd_en), .m_wr_en(b_m_wr_en), .m_addr(b_m_addr), .m_wdata(b_m_wdata),
    .m_mask(b_m_mask), .m_rdata(cfg_rdata), .m_busy(b_m_busy), .m_hit(cfg_hit), .o_err(b_o_err)
  );

  // Controller stand-in: a non-hit access raises busy for cfg_busy cycles after its enable pulse.
  always @(posedge clk or negedge rst_x) begin
    if (!rst_x)                              busy_left_a <= 0;
    else if (a_m_rd_en && cfg_hit)           busy_left_a <= 0;
    else if (a_m_rd_en || a_m_wr_en)         busy_left_a <= cfg_busy;
    else if (busy_left_a != 0)               busy_left_a <= busy_left_a - 1;
  end
  always @(posedge clk or negedge rst_x) begin
    if (!rst_x)                              busy_left_b <= 0;
    else if (b_m_rd_en && cfg_hit)           busy_left_b <= 0;
    else if (b_m_rd_en || b_m_wr_en)         busy_left_b <= cfg_busy;
    else if (busy_left_b != 0)               busy_left_b <= busy_left_b - 1;
  end
  assign a_m_busy = (busy_left_a != 0);
  assign b_m_busy = (busy_left_b != 0);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_gnt"},   {30'd0, a_s1_gnt, a_s0_gnt}, 32'd0);
    chk({tag, "_done"},  {30'd0, a_s1_done, a_s0_done}, 32'd0);
    chk({tag, "_en"},    {30'd0, a_m_wr_en, a_m_rd_en}, 32'd0);
    chk({tag, "_addr"},  a_m_addr, 32'd0);
    chk({tag, "_wdata"}, a_m_wdata, 32'd0);
    chk({tag, "_mask"},  {28'd0, a_m_mask}, 32'd0);
    chk({tag, "_rd0"},   a_s0_rdata, 32'd0);
    chk({tag, "_rd1"},   a_s1_rdata, 32'd0);
    chk({tag, "_err"},   {31'd0, a_o_err}, 32'd0);
  endtask

  task automatic scramble_inputs();
    s0_addr = $urandom; s1_addr = $urandom;
    s0_wdata = $urandom; s1_wdata = $urandom;
    s0_mask = 4'($urandom); s1_mask = 4'($urandom);
    s0_we = 1'($urandom); s1_we = 1'($urandom);
  endtask

  // One transaction from an idle arbiter; called at posedge+1.
  task automatic run_txn(input bit p, input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] mask, input bit hit, input int unsigned busy,
                         input logic [31:0] rdata);
    int unsigned lat;
    bit          issue, err;
    logic [3:0]  emask;
    logic [31:0] erd;
    logic        old_err;
    issue = !(we && mask == 4'd0);
    err   = 1'b0;
    if (!issue)               lat = 1;
    else if (!we && hit)      lat = 2;
    else if (busy == 0)       begin lat = 3;      err = 1'b1; end
    else if (busy > TO)       begin lat = 3 + TO; err = 1'b1; end
    else                      lat = 3 + busy;
    emask = we ? mask : 4'hF;
    if (err)     erd = 32'd0;
    else if (!we) erd = rdata;
    else         erd = exp_rdata[p];
    old_err = exp_err;

    cfg_hit = hit; cfg_busy = busy; cfg_rdata = rdata;
    if (p) begin
      s1_req = 1'b1; s1_we = we; s1_addr = addr; s1_wdata = wdata; s1_mask = mask;
    end else begin
      s0_req = 1'b1; s0_we = we; s0_addr = addr; s0_wdata = wdata; s0_mask = mask;
    end
    #1;
    chk("gnt", {30'd0, a_s1_gnt, a_s0_gnt}, p ? 32'd2 : 32'd1);
    @(posedge clk); #1;
    s0_req = 1'b0; s1_req = 1'b0;
    scramble_inputs();
    for (int k = 1; k <= lat; k++) begin
      chk("rd_en", {31'd0, a_m_rd_en}, {31'd0, (k == 1) && issue && !we});
      chk("wr_en", {31'd0, a_m_wr_en}, {31'd0, (k == 1) && issue && we});
      chk("m_addr", a_m_addr, addr);
      chk("m_mask", {28'd0, a_m_mask}, {28'd0, emask});
      if (issue) chk("m_wdata", a_m_wdata, wdata);
      chk("done", {30'd0, a_s1_done, a_s0_done}, (k == lat) ? (p ? 32'd2 : 32'd1) : 32'd0);
      chk("o_err", {31'd0, a_o_err}, {31'd0, (k == lat) ? (old_err | err) : old_err});
      if (k < lat) begin
        @(posedge clk); #1;
      end
    end
    exp_rdata[p] = erd;
    exp_err      = old_err | err;
    chk("rdata_own", p ? a_s1_rdata : a_s0_rdata, erd);
    chk("rdata_oth", p ? a_s0_rdata : a_s1_rdata, exp_rdata[!p]);
    @(posedge clk); #1;
    chk("done_clr", {30'd0, a_s1_done, a_s0_done}, 32'd0);
    for (int w = 0; w < 64 && a_m_busy; w++) begin
      @(posedge clk); #1;
    end
    chk("busy_drop", {31'd0, a_m_busy}, 32'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       favoured;
    logic [1:0] exp_a, exp_b;
    bit         p, we, hit;
    logic [3:0] mask;

    rst_x = 1'b0;
    s0_req = 1'b0; s1_req = 1'b0;
    scramble_inputs();
    cfg_hit = 1'b0; cfg_rdata = 32'd0; cfg_busy = 0;
    exp_rdata[0] = 32'd0; exp_rdata[1] = 32'd0; exp_err = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst_x = 1'b1;
    @(posedge clk); #1;

    // Both ports request continuously: grants every third cycle (read hits).
    favoured = 1'b0;
    cfg_hit = 1'b1; cfg_busy = 0; cfg_rdata = $urandom;
    s0_req = 1'b1; s1_req = 1'b1; s0_we = 1'b0; s1_we = 1'b0;
    #1;
    for (int c = 0; c < 16; c++) begin
      if (c % 3 == 0) begin
        exp_a    = favoured ? 2'b10 : 2'b01;
        favoured = ~favoured;
        exp_b    = 2'b10;
      end else begin
        exp_a = 2'b00;
        exp_b = 2'b00;
      end
      chk("rr_gnt", {30'd0, a_s1_gnt, a_s0_gnt}, {30'd0, exp_a});
      chk("fp_gnt", {30'd0, b_s1_gnt, b_s0_gnt}, {30'd0, exp_b});
      @(posedge clk); #1;
    end
    s0_req = 1'b0; s1_req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    exp_rdata[0] = cfg_rdata; exp_rdata[1] = cfg_rdata;
    chk("rr_rd0", a_s0_rdata, cfg_rdata);
    chk("rr_rd1", a_s1_rdata, cfg_rdata);
    chk("fp_rd0", b_s0_rdata, 32'd0);
    chk("fp_rd1", b_s1_rdata, cfg_rdata);

    // Directed cases.
    run_txn(1'b0, 1'b0, 32'h100, 32'h0, 4'h0, 1'b1, 0, 32'h11223344);
    run_txn(1'b1, 1'b1, 32'h200, 32'hA5A5A5A5, 4'b0011, 1'b0, 6, 32'hDEADBEEF);
    run_txn(1'b0, 1'b1, 32'h300, 32'h12345678, 4'b0000, 1'b0, 3, 32'h0);
    run_txn(1'b1, 1'b1, 32'h304, 32'h0BADF00D, 4'b1000, 1'b0, 1, 32'h0);
    run_txn(1'b0, 1'b0, 32'h308, 32'h0, 4'h0, 1'b0, TO, $urandom);

    // Randomized traffic with legal busy lengths.
    for (int i = 0; i < 24; i++) begin
      p    = 1'($urandom);
      we   = 1'($urandom);
      hit  = 1'($urandom);
      mask = 4'($urandom);
      run_txn(p, we, $urandom, $urandom, mask, hit, $urandom_range(1, 10), $urandom);
    end

    // Timeout, then a normal read with the error still sticky, then boundary timeout and missing busy.
    run_txn(1'b1, 1'b0, 32'h400, 32'h0, 4'h0, 1'b0, TO + 5, $urandom);
    run_txn(1'b0, 1'b0, 32'h404, 32'h0, 4'h0, 1'b0, 3, $urandom);
    run_txn(1'b0, 1'b0, 32'h408, 32'h0, 4'h0, 1'b0, TO + 1, $urandom);
    run_txn(1'b1, 1'b0, 32'h40C, 32'h0, 4'h0, 1'b0, 0, $urandom);

    // Reset in the middle of WAIT_FALL.
    cfg_hit = 1'b0; cfg_busy = 10; cfg_rdata = $urandom;
    s0_req = 1'b1; s0_we = 1'b1; s0_addr = 32'h500; s0_wdata = $urandom; s0_mask = 4'hF;
    #1;
    chk("mid_gnt", {31'd0, a_s0_gnt}, 32'd1);
    repeat (5) @(posedge clk);
    #1;
    s0_req = 1'b0;
    rst_x = 1'b0;
    #1;
    chk_all_zero("mid_rst");
    exp_rdata[0] = 32'd0; exp_rdata[1] = 32'd0; exp_err = 1'b0;
    for (int j = 0; j < 3; j++) begin
      @(posedge clk); #1;
      chk("rst_nodone", {30'd0, a_s1_done, a_s0_done}, 32'd0);
    end
    rst_x = 1'b1;
    @(posedge clk); #1;
    run_txn(1'b1, 1'b0, 32'h600, 32'h0, 4'h0, 1'b1, 0, $urandom);
    run_txn(1'b0, 1'b1, 32'h604, $urandom, 4'b0101, 1'b0, 2, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
